rect_cmd_queue: RTL and testbench
=================================

Name: rect_cmd_queue

Overview:
- Upstream command stage for the rectangle renderer.
- Accepts rectangle draw commands from the scene/game logic over a valid/ready handshake and buffers them in a FIFO.
- Issues commands one at a time: holds the attributes stable, raises the renderer's enable, waits for its done, then drops enable for a guaranteed gap before the next command.
- Lets producers queue a whole frame's rectangles without tracking renderer timing.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two.
- ADDR_W, 3: log2(DEPTH).
- DONE_BLANK, 2: cycles after enable rises during which rect_done is ignored.
- GAP, 1: minimum cycles rect_enable is held low between commands (>=1).

Ports:
- clk  input  1  system clock (50 MHz).
- resetn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  producer has a command.
- cmd_ready  output  1  queue can accept (= !full).
- cmd_x  input  9  origin x.
- cmd_y  input  8  origin y.
- cmd_w  input  9  width.
- cmd_h  input  8  height.
- cmd_back  input  3  background colour.
- cmd_border  input  1  border enable.
- cmd_border_color  input  3  border colour.
- rect_enable  output  1  renderer enable; high = draw.
- rect_x, rect_y, rect_w, rect_h, rect_back, rect_border, rect_border_color  output  9/8/9/8/3/1/3  registered attributes to the renderer.
- rect_done  input  1  renderer done level.
- fill_level  output  ADDR_W+1  current FIFO occupancy.
- busy  output  1  FSM not in IDLE.
- idle  output  1  FSM in IDLE and FIFO empty.
- drawn_count  output  16  completed rectangles; wraps at 65535 -> 0.

Behaviour:
- Reset (asynchronous, resetn=0):
  - FIFO pointers and fill_level go to 0; all rect_* attribute outputs go to 0.
  - rect_enable, busy and drawn_count go to 0; idle goes to 1; FSM enters IDLE.
  - rect_enable falls immediately, not at the next edge. Reset mid-draw aborts the rectangle and flushes all queued commands.
- Push:
  - A command is written on any clk edge with cmd_valid && cmd_ready. The 41-bit command is stored in field order x,y,w,h,back,border,border_color.
  - cmd_ready = (fill_level != DEPTH); there is no bypass when full, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves fill_level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, ARM, DRAW, GAP.
- IDLE:
  - Moves to LOAD when the FIFO is non-empty.
- LOAD (1 cycle):
  - Pops the head into the rect_* registers; rect_enable stays 0.
  - If the popped w==0 or h==0: command is discarded, drawn_count is not incremented, next state is GAP.
  - Otherwise next state is ARM.
- ARM:
  - rect_enable=1; counts DONE_BLANK cycles, ignoring rect_done, then moves to DRAW.
- DRAW:
  - rect_enable=1; waits for rect_done=1.
  - On that edge: drawn_count increments and next state is GAP.
- GAP:
  - rect_enable=0 for exactly GAP cycles.
  - Then moves to LOAD if the FIFO is non-empty, else IDLE.
- Latency and stability:
  - Latency from the first push into an empty queue to rect_enable=1 is 3 clk edges: push, IDLE->LOAD, LOAD->ARM.
  - rect_* attributes are stable from the LOAD edge until the next LOAD edge.
  - rect_enable is a registered output (except for the reset clear).
- busy is high in LOAD/ARM/DRAW/GAP. idle = (state==IDLE) && (fill_level==0).
- rect_done high outside DRAW is ignored.

Optional Feature:
- Macro RECT_CMD_QUEUE_CLIP_EN.
- Defined: at LOAD, commands are clipped to the 320x240 screen.
  - x>=320 or y>=240: command discarded, same path as zero area.
  - Otherwise rect_w = min(w, 320-x) and rect_h = min(h, 240-y), computed in 10/9-bit arithmetic.
- Undefined: attributes pass through unmodified; only zero-area discard applies.

Test Plan:
- Reset, push one cmd (x=10,y=20,w=4,h=3,back=3'b010) -> rect_enable rises 3 edges after the push. Attributes match. drawn_count=1 after rect_done is asserted in DRAW. idle=1 after GAP.
- Push 8 cmds with renderer stalled (rect_done=0) -> first pops. cmd_ready=0 only after fill_level reaches 8; fill_level=7 after the first pop. Completions drain all 8 in order with rect_enable low exactly GAP cycles between each.
- Hold rect_done=1 constantly -> each command still keeps rect_enable high for at least DONE_BLANK+1 cycles, and drawn_count advances by 1 per command.
- Push w=0 then h=0 then a valid cmd -> rect_enable never rises for the first two; drawn_count ends at 1.
- Assert resetn=0 mid-DRAW with 5 queued -> rect_enable=0 in the same cycle with no clk edge; fill_level=0, drawn_count=0.
- With RECT_CMD_QUEUE_CLIP_EN: push x=300,y=230,w=50,h=50 -> rect_w=20, rect_h=10. Push x=320 -> discarded.

Source files
------------

// File: rtl/rect_cmd_queue.sv
// Command FIFO and issue sequencer feeding the rectangle renderer.
// Optional build macro RECT_CMD_QUEUE_CLIP_EN clips each command to the 320x240 screen as it is loaded.
module rect_cmd_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int DONE_BLANK = 2,
  parameter int GAP        = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [2:0]        cmd_back,
  input  logic              cmd_border,
  input  logic [2:0]        cmd_border_color,
  output logic              rect_enable,
  output logic [8:0]        rect_x,
  output logic [7:0]        rect_y,
  output logic [8:0]        rect_w,
  output logic [7:0]        rect_h,
  output logic [2:0]        rect_back,
  output logic              rect_border,
  output logic [2:0]        rect_border_color,
  input  logic              rect_done,
  output logic [ADDR_W:0]   fill_level,
  output logic              busy,
  output logic              idle,
  output logic [15:0]       drawn_count
);

  localparam int CMD_W = 41;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_DRAW = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      ARM_LAST = (DONE_BLANK > 1) ? 8'(DONE_BLANK - 1) : 8'd0;
  localparam logic [7:0]      GAP_LAST = (GAP > 1) ? 8'(GAP - 1) : 8'd0;

  logic [CMD_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [7:0]        cnt;
  logic              push;
  logic              pop;
  logic              empty;

  logic [8:0] h_x;
  logic [7:0] h_y;
  logic [8:0] h_w;
  logic [7:0] h_h;
  logic [2:0] h_back;
  logic       h_border;
  logic [2:0] h_border_color;
  logic [8:0] ld_w;
  logic [7:0] ld_h;
  logic       off_screen;
  logic       discard;

  assign cmd_ready = (fill_level != FULL_LVL);
  assign empty     = (fill_level == '0);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_LOAD);

  assign {h_x, h_y, h_w, h_h, h_back, h_border, h_border_color} = mem[rd_ptr];

`ifdef RECT_CMD_QUEUE_CLIP_EN
  logic [9:0] room_w;
  logic [8:0] room_h;

  // Room left to the screen edge; only meaningful when the origin is on screen.
  assign room_w     = 10'd320 - {1'b0, h_x};
  assign room_h     = 9'd240 - {1'b0, h_y};
  assign off_screen = (h_x >= 9'd320) || (h_y >= 8'd240);
  assign ld_w       = ({1'b0, h_w} > room_w) ? room_w[8:0] : h_w;
  assign ld_h       = ({1'b0, h_h} > room_h) ? room_h[7:0] : h_h;
`else
  assign off_screen = 1'b0;
  assign ld_w       = h_w;
  assign ld_h       = h_h;
`endif

  assign discard = off_screen || (h_w == '0) || (h_h == '0);

  // NOTE: storage array carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_border_color};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + (ADDR_W+1)'(1);
        2'b01:   fill_level <= fill_level - (ADDR_W+1)'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  // NOTE: state_nx gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (!empty) state_nx = S_LOAD;
      S_LOAD: state_nx = discard ? S_GAP : S_ARM;
      S_ARM:  if (cnt == ARM_LAST) state_nx = S_DRAW;
      S_DRAW: if (rect_done) state_nx = S_GAP;
      S_GAP:  if (cnt == GAP_LAST) state_nx = empty ? S_IDLE : S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  // The async clear makes rect_enable drop the instant resetn falls, aborting any draw.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rect_enable <= 1'b0;
      drawn_count <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
      rect_enable <= (state_nx == S_ARM) || (state_nx == S_DRAW);
      if (state == S_DRAW && rect_done) drawn_count <= drawn_count + 16'd1;
    end
  end

  // Attributes change only on the LOAD edge and are held through ARM/DRAW/GAP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rect_x            <= '0;
      rect_y            <= '0;
      rect_w            <= '0;
      rect_h            <= '0;
      rect_back         <= '0;
      rect_border       <= 1'b0;
      rect_border_color <= '0;
    end else if (pop) begin
      rect_x            <= h_x;
      rect_y            <= h_y;
      rect_w            <= ld_w;
      rect_h            <= ld_h;
      rect_back         <= h_back;
      rect_border       <= h_border;
      rect_border_color <= h_border_color;
    end
  end

  assign busy = (state != S_IDLE);
  assign idle = (state == S_IDLE) && empty;

endmodule

// File: tb/tb_rect_cmd_queue.sv
// Directed self-checking bench for rect_cmd_queue; expected values are hand-derived from the FSM timing.
module tb_rect_cmd_queue;

  localparam int DONE_BLANK = 2;
  localparam int GAP        = 1;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [2:0]  cmd_back;
  logic        cmd_border;
  logic [2:0]  cmd_border_color;
  logic        rect_enable;
  logic [8:0]  rect_x;
  logic [7:0]  rect_y;
  logic [8:0]  rect_w;
  logic [7:0]  rect_h;
  logic [2:0]  rect_back;
  logic        rect_border;
  logic [2:0]  rect_border_color;
  logic        rect_done;
  logic [3:0]  fill_level;
  logic        busy;
  logic        idle;
  logic [15:0] drawn_count;

  int n_checks = 0;
  int n_err    = 0;

  rect_cmd_queue #(.DEPTH(8), .ADDR_W(3), .DONE_BLANK(DONE_BLANK), .GAP(GAP)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_x             (cmd_x),
    .cmd_y             (cmd_y),
    .cmd_w             (cmd_w),
    .cmd_h             (cmd_h),
    .cmd_back          (cmd_back),
    .cmd_border        (cmd_border),
    .cmd_border_color  (cmd_border_color),
    .rect_enable       (rect_enable),
    .rect_x            (rect_x),
    .rect_y            (rect_y),
    .rect_w            (rect_w),
    .rect_h            (rect_h),
    .rect_back         (rect_back),
    .rect_border       (rect_border),
    .rect_border_color (rect_border_color),
    .rect_done         (rect_done),
    .fill_level        (fill_level),
    .busy              (busy),
    .idle              (idle),
    .drawn_count       (drawn_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                          input logic [7:0] h, input logic [2:0] back);
    cmd_x            = x;
    cmd_y            = y;
    cmd_w            = w;
    cmd_h            = h;
    cmd_back         = back;
    cmd_border       = 1'b1;
    cmd_border_color = 3'd5;
    cmd_valid        = 1'b1;
    tick();
    cmd_valid        = 1'b0;
  endtask

  task automatic wait_enable(input string tag);
    int n = 0;
    while (!rect_enable && n < 40) begin
      tick();
      n++;
    end
    check(tag, rect_enable, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!idle && n < 40) begin
      tick();
      n++;
    end
    check(tag, idle, 1'b1);
  endtask

  // From a fresh rect_enable rise: sit through the blanking window, then complete the draw.
  task automatic finish_draw();
    repeat (DONE_BLANK) tick();
    rect_done = 1'b1;
    tick();
    rect_done = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    logic saw_enable;

    resetn = 1'b0; cmd_valid = 1'b0; rect_done = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_back = '0; cmd_border = 1'b0; cmd_border_color = '0;

    // Reset state
    #2;
    check("rst_enable", rect_enable, 0);
    check("rst_fill", fill_level, 0);
    check("rst_idle", idle, 1);
    check("rst_busy", busy, 0);
    check("rst_drawn", drawn_count, 0);
    check("rst_ready", cmd_ready, 1);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Single command: enable rises on the third edge counting the push edge
    push_cmd(9'd10, 8'd20, 9'd4, 8'd3, 3'b010);
    check("t1_fill_after_push", fill_level, 1);
    check("t1_idle_after_push", idle, 0);
    check("t1_enable_edge1", rect_enable, 0);
    tick();
    check("t1_busy_load", busy, 1);
    check("t1_enable_edge2", rect_enable, 0);
    tick();
    check("t1_enable_edge3", rect_enable, 1);
    check("t1_fill_popped", fill_level, 0);
    check("t1_x", rect_x, 10);
    check("t1_y", rect_y, 20);
    check("t1_w", rect_w, 4);
    check("t1_h", rect_h, 3);
    check("t1_back", rect_back, 3'b010);
    check("t1_border_color", rect_border_color, 5);
    repeat (DONE_BLANK + 2) tick();
    check("t1_enable_waiting", rect_enable, 1);
    check("t1_drawn_before_done", drawn_count, 0);
    rect_done = 1'b1;
    tick();
    rect_done = 1'b0;
    check("t1_drawn", drawn_count, 1);
    check("t1_enable_gap", rect_enable, 0);
    check("t1_busy_gap", busy, 1);
    repeat (GAP) tick();
    check("t1_idle_end", idle, 1);

    // Fill with renderer stalled; the first command pops on the third push edge
    for (int i = 0; i < 8; i++) push_cmd(9'(i + 1), 8'(2 * i), 9'(i + 1), 8'd1, 3'(i));
    check("t2_fill_7", fill_level, 7);
    check("t2_ready_at_7", cmd_ready, 1);
    check("t2_enable_stalled", rect_enable, 1);
    push_cmd(9'd9, 8'd16, 9'd9, 8'd1, 3'd0);
    check("t2_fill_8", fill_level, 8);
    check("t2_ready_full", cmd_ready, 0);
    cmd_x = 9'd99; cmd_w = 9'd9; cmd_h = 8'd9; cmd_valid = 1'b1;
    tick(); tick();
    cmd_valid = 1'b0;
    check("t2_fill_blocked", fill_level, 8);
    check("t2_drain_x0", rect_x, 1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        n = 0;
        do begin
          tick();
          n++;
        end while (!rect_enable && n < 20);
        // Low window is the GAP state plus the LOAD cycle
        check("t2_low_cycles", n, GAP + 1);
        repeat (DONE_BLANK) tick();
        check("t2_drain_x", rect_x, k + 1);
        check("t2_drain_enable", rect_enable, 1);
      end
      rect_done = 1'b1;
      tick();
      rect_done = 1'b0;
      check("t2_enable_fall", rect_enable, 0);
      check("t2_drawn", drawn_count, k + 2);
    end
    wait_idle("t2_idle_end");
    check("t2_fill_end", fill_level, 0);
    check("t2_drawn_end", drawn_count, 10);

    // rect_done held high: enable still high DONE_BLANK+1 cycles per command
    rect_done = 1'b1;
    push_cmd(9'd50, 8'd1, 9'd5, 8'd5, 3'd1);
    push_cmd(9'd51, 8'd1, 9'd5, 8'd5, 3'd2);
    for (int k = 0; k < 2; k++) begin
      wait_enable("t3_rise");
      check("t3_x", rect_x, 50 + k);
      hi = 0;
      while (rect_enable && hi < 20) begin
        hi++;
        tick();
      end
      check("t3_high_cycles", hi, DONE_BLANK + 1);
      check("t3_drawn", drawn_count, 11 + k);
    end
    wait_idle("t3_idle");
    rect_done = 1'b0;

    // Zero-area commands are discarded silently
    push_cmd(9'd100, 8'd1, 9'd0, 8'd5, 3'd3);
    push_cmd(9'd101, 8'd1, 9'd5, 8'd0, 3'd3);
    push_cmd(9'd102, 8'd1, 9'd2, 8'd2, 3'd3);
    wait_enable("t4_rise");
    check("t4_first_enabled_x", rect_x, 102);
    check("t4_drawn_no_discard_count", drawn_count, 12);
    finish_draw();
    check("t4_drawn", drawn_count, 13);
    wait_idle("t4_idle");

`ifdef RECT_CMD_QUEUE_CLIP_EN
    push_cmd(9'd300, 8'd230, 9'd50, 8'd50, 3'd4);
    push_cmd(9'd320, 8'd0, 9'd5, 8'd5, 3'd4);
    push_cmd(9'd10, 8'd0, 9'd1, 8'd1, 3'd4);
    wait_enable("clip_rise");
    check("clip_x", rect_x, 300);
    check("clip_w", rect_w, 20);
    check("clip_h", rect_h, 10);
    finish_draw();
    wait_enable("clip_rise2");
    check("clip_offscreen_skipped", rect_x, 10);
    finish_draw();
    check("clip_drawn", drawn_count, 15);
    wait_idle("clip_idle");
`endif

    // Reset mid-DRAW with 5 commands queued
    for (int i = 0; i < 6; i++) push_cmd(9'(200 + i), 8'd3, 9'd1, 8'd1, 3'd6);
    check("t5_enable_draw", rect_enable, 1);
    check("t5_fill_5", fill_level, 5);
    #3;
    resetn = 1'b0;
    #1;
    check("t5_enable_async", rect_enable, 0);
    check("t5_fill_flushed", fill_level, 0);
    check("t5_drawn_cleared", drawn_count, 0);
    check("t5_idle", idle, 1);
    check("t5_rect_x_cleared", rect_x, 0);
    tick();
    resetn = 1'b1;
    saw_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rect_enable) saw_enable = 1'b1;
    end
    check("t5_no_enable_after_flush", saw_enable, 0);
    check("t5_idle_after", idle, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
